// File: rtl/stream_cycle_gen.sv
// stream_cycle_gen: loads a pattern of up to DEPTH words, then streams it cyclically; STREAM_CYCLE_REPS_EN adds a repeat count
module stream_cycle_gen #(
  parameter int N = 8,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [N-1:0]  dIn,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic          stop,
`ifdef STREAM_CYCLE_REPS_EN
  input  logic [7:0]    reps,
`endif
  output logic [N-1:0]  sOut,
  output logic          sOut_valid,
  input  logic          sOut_ready,
  output logic [AW-1:0] len
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {LOAD, CYCLE} state_t;
  state_t state, state_nx;
  logic [N-1:0] mem [DEPTH];
  logic [AW-1:0] rd, len_inc, last_idx;
  logic load_end, wrap, done;
  assign len_inc = len + 1'b1;
  assign last_idx = len - 1'b1;
  assign load_end = in_valid && (in_last || len_inc == AW'(DEPTH));
  assign wrap = rd == last_idx;
`ifdef STREAM_CYCLE_REPS_EN
  logic [7:0] reps_q, pass;
  assign done = sOut_ready && wrap && reps_q != 8'd0 && pass + 8'd1 == reps_q;
  // capture the repeat count at the end of load and count completed passes while cycling
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      reps_q <= '0;
      pass <= '0;
    end else if (state == LOAD) begin
      pass <= '0;
      if (load_end) reps_q <= reps;
    end else if (sOut_ready && wrap) pass <= pass + 8'd1;
`else
  assign done = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= LOAD;
    else state <= state_nx;
  // next state and handshake outputs; sOut is forced to zero outside CYCLE
  always_comb begin
    state_nx = state;
    in_ready = state == LOAD;
    sOut_valid = state == CYCLE;
    sOut = state == CYCLE ? mem[rd[IW-1:0]] : '0;
    if (state == LOAD && load_end) state_nx = CYCLE;
    if (state == CYCLE && (stop || done)) state_nx = LOAD;
  end
  // pattern storage, fill count and read index
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      len <= '0;
      rd <= '0;
    end else if (state == LOAD) begin
      if (in_valid) begin
        mem[len[IW-1:0]] <= dIn;
        len <= len_inc;
      end
      rd <= '0;
    end else if (stop || done) begin
      len <= '0;
      rd <= '0;
    end else if (sOut_ready) rd <= wrap ? '0 : rd + 1'b1;
endmodule

// File: doc/stream_cycle_gen.md
# stream_cycle_gen

Parametrised cyclic stream generator: loads a pattern of up to DEPTH words of width N through a valid/ready input handshake, then emits the pattern repeatedly on a stream output with valid/ready flow control. It is the general successor to the fixed single-value cycle primitive. It sits between an `int` producer and any `stream` consumer in generated designs and adds variable pattern length, backpressure, and explicit stop/reload.

## Interface

Parameters:
- `N`, default 8 (`intN`): data word width.
- `DEPTH`, default 4: maximum pattern length; must be at least 1.
- `AW`, default `$clog2(DEPTH+1)`: width of the length and index counters. Derived; do not override.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `dIn`  in  N  pattern word.
- `in_valid`  in  1  `dIn` is valid.
- `in_last`  in  1  the current `dIn` is the final word of the pattern; qualified by `in_valid`.
- `in_ready`  out  1  the block accepts a pattern word.
- `stop`  in  1  request to end cycling and return to load.
- `sOut`  out  N  stream word.
- `sOut_valid`  out  1  `sOut` is valid.
- `sOut_ready`  in  1  consumer accepts `sOut`.
- `len`  out  AW  number of words currently loaded.

## Operation

- Storage is a register array `mem[DEPTH]`. It also uses a fill counter `len`, a read index `rd`, and a two-state FSM with states LOAD and CYCLE.
- Reset (asynchronous, while `nrst`=0):
  - state is LOAD;
  - `len`=0, `rd`=0, all `mem` entries 0;
  - outputs: `in_ready`=1, `sOut_valid`=0, `sOut`=0, `len`=0.
- LOAD:
  - `in_ready`=1 and `sOut_valid`=0.
  - On an input handshake (`in_valid` && `in_ready`): `mem[len]` <= `dIn` and `len` <= `len`+1.
  - If `in_last`=1 on that handshake, or the new `len` equals DEPTH: go to CYCLE with `rd`=0.
- CYCLE:
  - `in_ready`=0, `sOut_valid`=1, `sOut`=`mem[rd]` (combinational from the registered `rd`).
  - On an output handshake: `rd` <= (`rd`==`len`-1) ? 0 : `rd`+1.
  - `stop`=1 at a clock edge: go to LOAD with `len`=0 and `rd`=0. A handshake in the same cycle still counts as delivered. `mem` contents are kept.
- `stop` is ignored in LOAD. `in_valid` and `in_last` are ignored in CYCLE.
- If `in_last`=1 on the first word, the pattern length is 1 and the same word repeats every accepted cycle.
- `sOut` is 0 whenever `sOut_valid`=0.

## Timing

- The FSM accepts one input word per cycle in LOAD.
- Latency: `sOut_valid` rises on the cycle after the handshake that ends the load (the `in_last` word or the DEPTH-th word). The first word emitted is `mem[0]`.
- Throughput in CYCLE is one word per cycle while `sOut_ready`=1.
- While `sOut_ready`=0, `sOut` and `rd` hold stable. `sOut_valid` never drops without a handshake unless `stop` or reset occurs.
- Once `len`=DEPTH (auto-transition), `in_ready` falls on the next cycle. No write beyond DEPTH is possible.
- `in_ready` rises on the cycle after `stop` is sampled.
- Wrap-around: the word after `mem[len-1]` is `mem[0]`, with no bubble.
- A reset in mid-load or mid-cycle takes effect immediately, without waiting for a clock edge, and returns all outputs to their reset values.

## Configuration

- Macro: `STREAM_CYCLE_REPS_EN`.
- Defined:
  - Adds input `reps` (8 bits), sampled on the final load handshake.
  - A pass counter increments each time `rd` wraps from `len`-1 to 0 on a handshake.
  - When the counter reaches `reps`, the FSM returns to LOAD, exactly as for `stop`.
  - `reps`=0 means cycle indefinitely.
  - Reset clears the pass counter.
- Undefined: no `reps` port and no pass counter; cycling ends only on `stop` or reset.

## Test plan

- N=8, DEPTH=4. Load 42 with `in_last`=1, `sOut_ready`=1 → `sOut`=42 with `sOut_valid`=1 on every cycle from the next cycle onward; `len`=1.
- Load 1, 2, 3 with `in_last` on 3 → `sOut` sequence 1,2,3,1,2,3,1; `in_ready`=0 throughout.
- Load 5, 6, 7, 8 with no `in_last`, then drive 9 → `in_ready`=0 after 8; 9 is never emitted; output is 5,6,7,8,5.
- Backpressure: pattern 1,2,3, drop `sOut_ready` for 3 cycles while `sOut`=2 → `sOut` holds 2 and `sOut_valid`=1; the sequence resumes 2,3,1.
- `stop` asserted while `sOut`=3 with a handshake → 3 is counted as delivered. Next cycle `in_ready`=1, `len`=0, `sOut_valid`=0. Reload 7 → `sOut`=7 repeats.
- `nrst` pulsed low mid-cycle → all outputs are 0 and `in_ready`=1 immediately. With `STREAM_CYCLE_REPS_EN` defined, `reps`=2 and pattern 9,10 → output 9,10,9,10, then `sOut_valid`=0 and `in_ready`=1.
